// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the step_ctrl slice (run/stop and direction
// control for a 3-bit up/down counter).
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        REVERSE = 2'd2
    } state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int unsigned TICK_DIV_DEFAULT        = 50;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/step_ctrl_if.sv
// Control bus from step_ctrl to the downstream up/down counter.
interface step_ctrl_if;

    logic en;
    logic dir;
    logic running;

    modport master (output en, output dir, output running);
    modport slave  (input  en, input  dir, input  running);

endinterface

// File: rtl/step_ctrl_debounce.sv
// btn_debounce: 2-flop synchroniser, counting debouncer and registered
// one-cycle press pulse on the rising edge of the debounced level.
module btn_debounce
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int unsigned  CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // Any cycle of agreement restarts the stability count.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: debounced run/dir buttons drive an IDLE/RUN/REVERSE FSM that
// strobes en every TICK_DIV cycles. Macro STEP_CTRL_SINGLE_STEP_EN adds btn_step.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned TICK_DIV        = TICK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_run,
    input  logic        btn_dir,
    input  logic        btn_step,
    step_ctrl_if.master ctrl
);

    localparam int unsigned   TW        = cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic run_press;
    logic dir_press;
    logic step_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_run),
        .press (run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_dir),
        .press (dir_press)
    );

`ifdef STEP_CTRL_SINGLE_STEP_EN
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_step),
        .press (step_press)
    );
`else
    logic unused_btn_step;
    assign unused_btn_step = btn_step;
    assign step_press      = 1'b0;
`endif

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] tick;
    logic [TW-1:0] tick_next;
    logic          en_q;
    logic          en_next;
    logic          dir_q;
    logic          dir_next;
    logic          running_q;

    // Priority: run press, then dir press, then step press.
    always_comb begin
        state_next = state;
        tick_next  = tick + TW'(1);
        en_next    = 1'b0;
        dir_next   = dir_q;
        case (state)
            IDLE: begin
                tick_next = '0;
                if (run_press) begin
                    state_next = RUN;
                end else if (dir_press) begin
                    dir_next = ~dir_q;
                end else if (step_press) begin
                    en_next = 1'b1;
                end
            end
            RUN: begin
                if (run_press) begin
                    state_next = IDLE;
                    tick_next  = '0;
                end else if (dir_press) begin
                    state_next = REVERSE;
                    tick_next  = '0;
                end else if (tick == TICK_LAST) begin
                    tick_next = '0;
                    en_next   = 1'b1;
                end
            end
            REVERSE: begin
                if (run_press) begin
                    state_next = IDLE;
                    tick_next  = '0;
                    dir_next   = ~dir_q;
                end else if (tick == TICK_LAST) begin
                    state_next = RUN;
                    tick_next  = '0;
                    dir_next   = ~dir_q;
                end
            end
            default: begin
                state_next = IDLE;
                tick_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick      <= '0;
            en_q      <= 1'b0;
            dir_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state     <= state_next;
            tick      <= tick_next;
            en_q      <= en_next;
            dir_q     <= dir_next;
            running_q <= (state_next != IDLE);
        end
    end

    assign ctrl.en      = en_q;
    assign ctrl.dir     = dir_q;
    assign ctrl.running = running_q;

endmodule
